// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: tag compare, per-set valid bits, 4-beat line refill.
// Optional hit/miss statistics counters are built in when ICACHE_STAT_EN is defined.
`timescale 1ns/1ps
module icache_ctrl #(
    parameter int unsigned TAG_W = 20,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned OFF_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req_i,
    input  logic [31:0]                   cpu_addr_i,
    input  logic                          flush_i,
    output logic                          cpu_ready_o,
    output logic                          cpu_rvalid_o,
    output logic [31:0]                   cpu_rdata_o,
    output logic [IDX_W-1:0]              tag_index_o,
    output logic                          tag_we_o,
    output logic [TAG_W-1:0]              tag_wdata_o,
    input  logic [TAG_W-1:0]              tag_rdata_i,
    output logic [IDX_W-1:0]              data_index_o,
    output logic                          data_we_o,
    output logic [(32<<(OFF_W-2))-1:0]    data_wdata_o,
    input  logic [(32<<(OFF_W-2))-1:0]    data_rdata_i,
    output logic                          mem_req_o,
    output logic [31:0]                   mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]                   hit_cnt_o,
    output logic [31:0]                   miss_cnt_o
`endif
);

    localparam int unsigned SETS   = 1 << IDX_W;
    localparam int unsigned LINE_W = 32 << (OFF_W - 2);

    typedef enum logic [2:0] {StIdle, StLookup, StMissReq, StRefill, StWrite} state_e;

    state_e                 state_q, state_d;
    logic [31:2]            addr_q, addr_d;
    logic [SETS-1:0]        valid_q, valid_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [OFF_W-3:0]       cnt_q, cnt_d;
    logic [LINE_W-1:0]      line_q, line_d;

    logic [IDX_W-1:0]       set_idx;
    logic [OFF_W-3:0]       word_sel;
    logic                   hit;
    logic                   unused_addr_bits;

    // Fetch addresses are word aligned; the byte-select bits carry no information.
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign set_idx  = addr_q[OFF_W +: IDX_W];
    assign word_sel = addr_q[OFF_W-1:2];
    assign hit      = valid_q[set_idx] && (tag_rdata_i == addr_q[31 -: TAG_W]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        cpu_ready_o  = 1'b0;
        cpu_rvalid_o = 1'b0;
        cpu_rdata_o  = '0;
        tag_index_o  = '0;
        tag_we_o     = 1'b0;
        tag_wdata_o  = '0;
        data_index_o = '0;
        data_we_o    = 1'b0;
        data_wdata_o = '0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;

        // A flush while busy is deferred so the in-flight line still lands valid first.
        if (flush_i && (state_q != StIdle)) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cpu_ready_o  = ~flush_pend_q & ~flush_i;
                tag_index_o  = cpu_addr_i[OFF_W +: IDX_W];
                data_index_o = cpu_addr_i[OFF_W +: IDX_W];
                if (flush_i || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
                if (cpu_req_i && !flush_pend_q && !flush_i) begin
                    addr_d  = cpu_addr_i[31:2];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                tag_index_o  = set_idx;
                data_index_o = set_idx;
                if (hit) begin
                    cpu_rvalid_o = 1'b1;
                    cpu_rdata_o  = data_rdata_i[{word_sel, 5'b0} +: 32];
                    state_d      = StIdle;
                end else begin
                    state_d = StMissReq;
                end
            end
            StMissReq: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                if (mem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (mem_rvalid_i) begin
                    line_d[{cnt_q, 5'b0} +: 32] = mem_rdata_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                tag_index_o      = set_idx;
                data_index_o     = set_idx;
                tag_we_o         = 1'b1;
                data_we_o        = 1'b1;
                tag_wdata_o      = addr_q[31 -: TAG_W];
                data_wdata_o     = line_q;
                valid_d[set_idx] = 1'b1;
                cpu_rvalid_o     = 1'b1;
                cpu_rdata_o      = line_q[{word_sel, 5'b0} +: 32];
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StLookup) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomised scoreboard bench for icache_ctrl with tag/data RAM and burst-memory models.
`timescale 1ns/1ps
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic         flush_i = 1'b0;
    logic         cpu_ready_o, cpu_rvalid_o;
    logic [31:0]  cpu_rdata_o;
    logic [7:0]   tag_index_o, data_index_o;
    logic         tag_we_o, data_we_o;
    logic [19:0]  tag_wdata_o, tag_rdata_i;
    logic [127:0] data_wdata_o, data_rdata_i;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0]  mem_rdata_i = '0;
`ifdef ICACHE_STAT_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    icache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .flush_i(flush_i),
        .cpu_ready_o(cpu_ready_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .tag_index_o(tag_index_o), .tag_we_o(tag_we_o), .tag_wdata_o(tag_wdata_o),
        .tag_rdata_i(tag_rdata_i),
        .data_index_o(data_index_o), .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef ICACHE_STAT_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // Backing memory content is a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} ^ 32'hA5C3_0F19) * 32'h0001_0003 + 32'h1234_5678;
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word({a[31:4], 4'h0} + 32'(w * 4));
        return l;
    endfunction

    // Tag table and data array: synchronous read, write on the same edge.
    logic [19:0]  tag_mem[256];
    logic [127:0] data_mem[256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            tag_mem[i]  = 20'($urandom);
            data_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    end
    always @(posedge clk) begin
        if (tag_we_o) tag_mem[tag_index_o] <= tag_wdata_o;
        if (data_we_o) data_mem[data_index_o] <= data_wdata_o;
        tag_rdata_i  <= tag_mem[tag_index_o];
        data_rdata_i <= data_mem[data_index_o];
    end

    // Burst memory: random grant delay, gapped beats, stray beats when idle.
    int          rsp_phase = 0, rsp_wait = 0, rsp_beats = 0, force_wait = -1;
    logic [31:0] rsp_addr = '0;
    initial forever begin
        @(posedge clk);
        #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (!rst_n) begin
            rsp_phase = 0;
            continue;
        end
        if (rsp_phase == 0 && mem_req_o) begin
            rsp_phase = 1;
            rsp_wait  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 5));
            rsp_addr  = mem_addr_o;
        end
        if (rsp_phase == 1) begin
            if (rsp_wait == 0) begin
                mem_gnt_i = 1'b1;
                rsp_phase = 2;
                rsp_beats = 0;
            end else begin
                rsp_wait--;
            end
        end else if (rsp_phase == 2) begin
            if ($urandom % 3 != 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(rsp_addr + 32'(rsp_beats * 4));
                rsp_beats++;
                if (rsp_beats == 4) rsp_phase = 0;
            end
        end else if ($urandom % 6 == 0) begin
            mem_rvalid_i = 1'b1;
        end
    end

    // Reference model: per-set valid/tag, updated when a request is accepted.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
        int          acc;
    } exp_t;
    exp_t        sb[$];
    bit          mv[256];
    logic [19:0] mt[256];
    int          m_hits = 0, m_misses = 0;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every returned word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_o) begin
                if (sb.size() == 0) fail_now("mem_req_without_request");
                else chk("mem_addr", 128'(mem_addr_o), 128'({sb[0].addr[31:4], 4'h0}));
            end
            if (tag_we_o) begin
                if (sb.size() == 0) fail_now("tag_we_without_request");
                else begin
                    chk("write_on_hit", 128'(sb[0].hit), 128'(0));
                    chk("tag_wdata", 128'(tag_wdata_o), 128'(sb[0].addr[31:12]));
                    chk("wr_index", 128'({tag_index_o, data_index_o}),
                        128'({sb[0].addr[11:4], sb[0].addr[11:4]}));
                    chk("data_we", 128'(data_we_o), 128'(1));
                    chk("data_wdata", data_wdata_o, exp_line(sb[0].addr));
                end
            end
            if (cpu_rvalid_o) begin
                if (sb.size() == 0) fail_now("spurious_rvalid");
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", 128'(cpu_rdata_o), 128'(e.data));
                    if (e.hit) chk("hit_latency", 128'(cyc - e.acc), 128'(0));
                    else chk("miss_latency_ge6", 128'((cyc - e.acc) >= 6), 128'(1));
                end
            end
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic issue(input logic [31:0] a);
        int   t = 0;
        bit   ok = 1'b0;
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        while (!ok) begin
            @(negedge clk);
            if (cpu_ready_o) ok = 1'b1;
            else if (++t > 300) break;
        end
        if (!ok) fail_now("accept_timeout");
        else begin
            exp_t e;
            e.addr = a;
            e.data = mem_word(a);
            e.hit  = mv[a[11:4]] && (mt[a[11:4]] == a[31:12]);
            e.acc  = cyc + 1;
            if (e.hit) m_hits++;
            else m_misses++;
            mv[a[11:4]] = 1'b1;
            mt[a[11:4]] = a[31:12];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            if (++t > 500) begin
                fail_now("response_timeout");
                sb.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(negedge clk);
        chk("ready_during_flush", 128'(cpu_ready_o), 128'(0));
        model_clear();
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int beats);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(rsp_phase == ph && rsp_beats >= beats) && t < 200);
        if (t >= 200) fail_now("burst_wait_timeout");
    endtask

    initial begin
        int t;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(cpu_ready_o), 128'(1));
        chk("rst_rvalid", 128'(cpu_rvalid_o), 128'(0));
        chk("rst_mem_req", 128'(mem_req_o), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr_o), 128'(0));
        chk("rst_we", 128'({tag_we_o, data_we_o}), 128'(0));
`ifdef ICACHE_STAT_EN
        chk("rst_counts", 128'({hit_cnt_o, miss_cnt_o}), 128'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, hit in same line, conflicting tag, re-miss.
        issue(32'h0000_1234); wait_idle();
        issue(32'h0000_1238); wait_idle();
        issue(32'h0000_123C); wait_idle();
        issue(32'h0001_1230); wait_idle();
        issue(32'h0000_1230); wait_idle();
        issue(32'h0000_1230); wait_idle();
        // Index boundary sets are independent.
        issue(32'h0000_0FF0); wait_idle();
        issue(32'h0000_1000); wait_idle();
        issue(32'h0000_0FF4); wait_idle();

        // Slow grant.
        force_wait = 5;
        issue(32'h0000_4448); wait_idle();
        force_wait = -1;

        // Flush in idle together with a request: not accepted that cycle.
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_1238;
        pulse_flush();
        issue(32'h0000_1238); wait_idle();

        // Flush during refill: line returned, then one idle cycle not ready.
        issue(32'h0000_2220);
        wait_phase(2, 0);
        @(posedge clk);
        #1;
        pulse_flush();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cpu_rvalid_o && t < 300);
        if (t >= 300) fail_now("flush_refill_timeout");
        @(negedge clk);
        chk("ready_after_pending_flush", 128'(cpu_ready_o), 128'(0));
        @(negedge clk);
        chk("ready_after_flush_done", 128'(cpu_ready_o), 128'(1));
        @(posedge clk);
        #1;
        wait_idle();
        issue(32'h0000_2220); wait_idle();

        // Reset during refill after two beats.
        issue(32'h0000_5670);
        wait_phase(2, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        chk("midrst_ready", 128'(cpu_ready_o), 128'(1));
        chk("midrst_we", 128'({tag_we_o, data_we_o, cpu_rvalid_o}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_we", 128'(tag_we_o), 128'(0));
        @(posedge clk);
        #1;
        issue(32'h0000_5670); wait_idle();
        issue(32'h0000_5674); wait_idle();

        // Random traffic concentrated on a few sets and tags.
        for (int n = 0; n < 300; n++) begin
            logic [7:0]  ix;
            logic [31:0] a;
            case ($urandom % 5)
                0: ix = 8'h00;
                1: ix = 8'h01;
                2: ix = 8'h23;
                3: ix = 8'hFF;
                default: ix = 8'($urandom);
            endcase
            a = {20'($urandom_range(0, 2)), ix, 4'($urandom)};
            if ($urandom % 16 == 0) pulse_flush();
            issue(a);
            if ($urandom % 10 == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                pulse_flush();
            end
            wait_idle();
        end

`ifdef ICACHE_STAT_EN
        chk("hit_cnt", 128'(hit_cnt_o), 128'(m_hits));
        chk("miss_cnt", 128'(miss_cnt_o), 128'(m_misses));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "bench timed out");
    end

endmodule
